// File: rtl/parking_fee_calc.sv
// Parking fee calculator: stamps slots on entry, bills on exit.
// Ports: clk, reset (async active-low), timer_count, entry/exit requests,
// ready, occupied bitmap, {fee_slot, duration, fee} with fee_valid, err.
module parking_fee_calc #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int TIME_W     = 10,
  parameter int UNIT_SHIFT = 4,
  parameter int BASE_FEE   = 2,
  parameter int RATE       = 1,
  parameter int FEE_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TIME_W-1:0]    timer_count,
  input  logic                 entry_valid,
  input  logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_valid,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 ready,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 fee_valid,
  output logic [SLOT_W-1:0]    fee_slot,
  output logic [TIME_W-1:0]    duration,
  output logic [FEE_W-1:0]     fee,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int RAW_W = TIME_W + 33;
  localparam logic [SLOT_W:0] SLOT_LIM = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [TIME_W:0] ROUND = (TIME_W+1)'(2**UNIT_SHIFT - 1);
  localparam logic [RAW_W-1:0] FEE_MAX = RAW_W'(2**FEE_W - 1);

  state_t              state;
  logic [TIME_W-1:0]   entry_time [NUM_SLOTS];
  logic [SLOT_W-1:0]   slot_q;
  logic [TIME_W-1:0]   dur_q;
  logic [FEE_W-1:0]    fee_q;

  logic                entry_in;
  logic                exit_in;
  logic                exit_ok;
  logic                entry_ok;
  logic                exit_bad;
  logic                entry_bad;
  logic [NUM_SLOTS-1:0] occ_next;
  logic [TIME_W:0]     units;
  logic [RAW_W-1:0]    raw;
  logic [FEE_W-1:0]    fee_sat;

  assign entry_in = ({1'b0, entry_slot} < SLOT_LIM);
  assign exit_in  = ({1'b0, exit_slot} < SLOT_LIM);

  assign exit_ok = exit_valid && ready && exit_in
                && occupied[exit_slot];
  assign exit_bad = exit_valid && !exit_ok;

  // An entry into the slot being vacated on the same edge re-stamps it.
  assign entry_ok = entry_valid && entry_in
                 && (!occupied[entry_slot]
                     || (exit_ok && exit_slot == entry_slot));
  assign entry_bad = entry_valid && !entry_ok;

  always_comb begin
    occ_next = occupied;
    if (exit_ok)  occ_next[exit_slot]  = 1'b0;
    if (entry_ok) occ_next[entry_slot] = 1'b1;
  end

  // Ceiling division to billing units, then saturate the fee.
  assign units = ({1'b0, dur_q} + ROUND) >> UNIT_SHIFT;
  assign raw   = RAW_W'(BASE_FEE) + RAW_W'(units) * RAW_W'(RATE);

  always_comb begin
    fee_sat = raw[FEE_W-1:0];
    if (raw > FEE_MAX) fee_sat = FEE_MAX[FEE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b0;
      occupied  <= '0;
      fee_valid <= 1'b0;
      fee_slot  <= '0;
      duration  <= '0;
      fee       <= '0;
      err       <= 1'b0;
      slot_q    <= '0;
      dur_q     <= '0;
      fee_q     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        entry_time[i] <= '0;
      end
    end else begin
      occupied  <= occ_next;
      err       <= entry_bad | exit_bad;
      fee_valid <= 1'b0;
      if (entry_ok) entry_time[entry_slot] <= timer_count;
      unique case (state)
        IDLE: begin
          if (exit_ok) begin
            slot_q <= exit_slot;
            dur_q  <= timer_count - entry_time[exit_slot];
            state  <= CALC;
            ready  <= 1'b0;
          end else begin
            ready  <= 1'b1;
          end
        end
        CALC: begin
          fee_q <= fee_sat;
          state <= DONE;
        end
        DONE: begin
          fee_valid <= 1'b1;
          fee_slot  <= slot_q;
          duration  <= dur_q;
          fee       <= fee_q;
          state     <= IDLE;
          ready     <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
